// File: rtl/osr_train_tx_pkg.sv
// Shared types and constants for the OSR transmit link trainer.
// The state encoding is fixed so that upset or unused codes (6, 7) decode back to Start.
package osr_train_pkg;

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_OSR_RST = 3'd1,
    S_WRST    = 3'd2,
    S_TRAIN   = 3'd3,
    S_MARKER  = 3'd4,
    S_DATA    = 3'd5
  } state_e;

  localparam int STATE_W = 3;
  localparam int WCNT_W  = 3;
  localparam int TCNT_W  = 8;

  localparam int          DEF_WIDTH     = 12;
  localparam logic [11:0] DEF_TRAIN_PAT = 12'hFC0;
  localparam logic [11:0] DEF_MARK_PAT  = 12'h5A3;
  localparam logic [11:0] DEF_IDLE_PAT  = 12'h0F0;

endpackage

// File: rtl/osr_train_tx_if.sv
// User-side word handshake and serializer-side outputs of the link trainer.
interface osr_train_tx_if #(
    parameter int WIDTH = 12
);
    import osr_train_pkg::*;

    // DIN is consumed on a rising edge where DIN_VLD && DIN_RDY; DIN_RDY never depends on DIN_VLD.
    logic             RETRAIN;
    logic [WIDTH-1:0] DIN;
    logic             DIN_VLD;
    logic             DIN_RDY;
    logic [WIDTH-1:0] DOUT;
    logic             OSR_RST;
    logic             TRAINING;
    logic             LINK_UP;
    state_e           STATE_DBG;

    modport master (
        output RETRAIN, DIN, DIN_VLD,
        input  DIN_RDY, DOUT, OSR_RST, TRAINING, LINK_UP, STATE_DBG
    );

    modport slave (
        input  RETRAIN, DIN, DIN_VLD,
        output DIN_RDY, DOUT, OSR_RST, TRAINING, LINK_UP, STATE_DBG
    );
endinterface

// File: rtl/osr_train_tx_vote.sv
// Bitwise 2-of-3 majority voter used on every triplicated register.
module tmr_vote #(
    parameter int W = 1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] y_o
);
    assign y_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// File: rtl/osr_train_tx.sv
// Transmit link trainer: serializer reset, training words, one marker, then user data.
// State, counters and outputs are held in three copies that all reload from voted values.
module osr_train_tx
    import osr_train_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter int               RST_CYC    = 5,
    parameter int               SYNC_WORDS = 64,
    parameter logic [WIDTH-1:0] TRAIN_PAT  = WIDTH'(DEF_TRAIN_PAT),
    parameter logic [WIDTH-1:0] MARK_PAT   = WIDTH'(DEF_MARK_PAT),
    parameter logic [WIDTH-1:0] IDLE_PAT   = WIDTH'(DEF_IDLE_PAT)
) (
    input  logic           CLK,
    input  logic           RST,
    osr_train_tx_if.slave  bus
);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(RST_CYC - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(SYNC_WORDS - 1);

    (* keep = "true", preserve = "true" *) logic [STATE_W-1:0] state_q0, state_q1, state_q2;
    (* keep = "true", preserve = "true" *) logic [WCNT_W-1:0]  wcnt_q0, wcnt_q1, wcnt_q2;
    (* keep = "true", preserve = "true" *) logic [TCNT_W-1:0]  tcnt_q0, tcnt_q1, tcnt_q2;
    (* keep = "true", preserve = "true" *) logic [WIDTH-1:0]   dout_q0, dout_q1, dout_q2;
    (* keep = "true", preserve = "true" *) logic [2:0]         flags_q0, flags_q1, flags_q2;

    logic [STATE_W-1:0] state_vb;
    logic [WCNT_W-1:0]  wcnt_v;
    logic [TCNT_W-1:0]  tcnt_v;
    logic [WIDTH-1:0]   dout_v;
    logic [2:0]         flags_v;
    state_e             state_v;

    state_e             state_d;
    logic [WCNT_W-1:0]  wcnt_d;
    logic [TCNT_W-1:0]  tcnt_d;
    logic [WIDTH-1:0]   dout_d;
    logic [2:0]         flags_d;
    logic               rdy;

    tmr_vote #(.W(STATE_W)) u_vote_state (.a_i(state_q0), .b_i(state_q1), .c_i(state_q2), .y_o(state_vb));
    tmr_vote #(.W(WCNT_W))  u_vote_wcnt  (.a_i(wcnt_q0),  .b_i(wcnt_q1),  .c_i(wcnt_q2),  .y_o(wcnt_v));
    tmr_vote #(.W(TCNT_W))  u_vote_tcnt  (.a_i(tcnt_q0),  .b_i(tcnt_q1),  .c_i(tcnt_q2),  .y_o(tcnt_v));
    tmr_vote #(.W(WIDTH))   u_vote_dout  (.a_i(dout_q0),  .b_i(dout_q1),  .c_i(dout_q2),  .y_o(dout_v));
    tmr_vote #(.W(3))       u_vote_flags (.a_i(flags_q0), .b_i(flags_q1), .c_i(flags_q2), .y_o(flags_v));

    assign state_v = state_e'(state_vb);

    // Ready drops with RETRAIN so no word is consumed on the cycle that leaves Data.
    assign rdy = (state_v == S_DATA) && !bus.RETRAIN;

    always_comb begin
        state_d = S_START;
        unique case (state_v)
            S_START:   state_d = S_OSR_RST;
            S_OSR_RST: state_d = (wcnt_v == WCNT_LAST) ? S_WRST : S_OSR_RST;
            S_WRST:    state_d = S_TRAIN;
            S_TRAIN:   state_d = (bus.RETRAIN || tcnt_v != TCNT_LAST) ? S_TRAIN : S_MARKER;
            S_MARKER:  state_d = bus.RETRAIN ? S_TRAIN : S_DATA;
            S_DATA:    state_d = bus.RETRAIN ? S_TRAIN : S_DATA;
            default:   state_d = S_START;
        endcase

        wcnt_d = (state_v == S_OSR_RST) ? wcnt_v + WCNT_W'(1) : '0;
        tcnt_d = (state_v == S_TRAIN && !bus.RETRAIN) ? tcnt_v + TCNT_W'(1) : '0;

        // Outputs decode from the next state so they line up with it after the edge.
        dout_d = '0;
        unique case (state_d)
            S_WRST, S_TRAIN: dout_d = TRAIN_PAT;
            S_MARKER:        dout_d = MARK_PAT;
            S_DATA:          dout_d = (bus.DIN_VLD && rdy) ? bus.DIN : IDLE_PAT;
            default:         dout_d = '0;
        endcase

        flags_d = {state_d == S_OSR_RST, state_d == S_TRAIN, state_d == S_DATA};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q0 <= S_START;
            state_q1 <= S_START;
            state_q2 <= S_START;
            wcnt_q0  <= '0;
            wcnt_q1  <= '0;
            wcnt_q2  <= '0;
            tcnt_q0  <= '0;
            tcnt_q1  <= '0;
            tcnt_q2  <= '0;
            dout_q0  <= '0;
            dout_q1  <= '0;
            dout_q2  <= '0;
            flags_q0 <= '0;
            flags_q1 <= '0;
            flags_q2 <= '0;
        end else begin
            state_q0 <= state_d;
            state_q1 <= state_d;
            state_q2 <= state_d;
            wcnt_q0  <= wcnt_d;
            wcnt_q1  <= wcnt_d;
            wcnt_q2  <= wcnt_d;
            tcnt_q0  <= tcnt_d;
            tcnt_q1  <= tcnt_d;
            tcnt_q2  <= tcnt_d;
            dout_q0  <= dout_d;
            dout_q1  <= dout_d;
            dout_q2  <= dout_d;
            flags_q0 <= flags_d;
            flags_q1 <= flags_d;
            flags_q2 <= flags_d;
        end
    end

    assign bus.DIN_RDY   = rdy;
    assign bus.DOUT      = dout_v;
    assign bus.OSR_RST   = flags_v[2];
    assign bus.TRAINING  = flags_v[1];
    assign bus.LINK_UP   = flags_v[0];
    assign bus.STATE_DBG = state_v;
endmodule

// File: tb/tb_osr_train_tx.sv
// Self-checking bench for osr_train_tx with default parameters.
module tb_osr_train_tx;
  import osr_train_pkg::*;

  localparam logic [11:0] TP = 12'hFC0;
  localparam logic [11:0] MP = 12'h5A3;
  localparam logic [11:0] IP = 12'h0F0;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;
  logic [14:0] exp_q[$];
  logic [14:0] obs;

  osr_train_tx_if #(.WIDTH(12)) bus ();

  osr_train_tx u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  assign obs = {bus.OSR_RST, bus.TRAINING, bus.LINK_UP, bus.DOUT};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [14:0] pk(input logic o, input logic t, input logic l,
                                     input logic [11:0] d);
    return {o, t, l, d};
  endfunction

  // expected outputs after edge e following reset release, DIN_VLD low
  function automatic logic [14:0] boot_exp(input int e);
    if (e <= 5)       return pk(1'b1, 1'b0, 1'b0, 12'h000);
    else if (e == 6)  return pk(1'b0, 1'b0, 1'b0, TP);
    else if (e <= 70) return pk(1'b0, 1'b1, 1'b0, TP);
    else if (e == 71) return pk(1'b0, 1'b0, 1'b0, MP);
    else              return pk(1'b0, 1'b0, 1'b1, IP);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_boot(input string tag);
    logic [14:0] e;
    release_reset();
    for (int k = 1; k <= 74; k++) begin
      exp_q.push_back(boot_exp(k));
      tick();
      e = exp_q.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s edge %0d: got %h required %h", tag, k, obs, e);
      end
      n_run++;
      if (bus.DIN_RDY !== (k >= 72)) begin
        n_fail++;
        $display("FAIL %s rdy edge %0d: got %b required %b", tag, k, bus.DIN_RDY, (k >= 72));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.RETRAIN = 1'b0;
    bus.DIN     = 12'h000;
    bus.DIN_VLD = 1'b0;
    repeat (2) tick();
    n_run++;
    if (obs !== 15'h0 || bus.DIN_RDY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got %h rdy %b required 0000 rdy 0", obs, bus.DIN_RDY);
    end
    run_boot("boot");
  endtask

  task automatic test_data();
    logic [14:0] e;
    logic [11:0] w;
    logic        v;
    logic [11:0] words[2];
    words[0] = 12'h123;
    words[1] = 12'h456;
    for (int k = 0; k < 2; k++) begin
      bus.DIN_VLD = 1'b1;
      bus.DIN     = words[k];
      n_run++;
      if (bus.DIN_RDY !== 1'b1) begin
        n_fail++;
        $display("FAIL data_rdy %0d: got %b required 1", k, bus.DIN_RDY);
      end
      exp_q.push_back(pk(1'b0, 1'b0, 1'b1, words[k]));
      tick();
      e = exp_q.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL data_word %0d: got %h required %h", k, obs, e);
      end
    end
    for (int k = 0; k < 12; k++) begin
      v = ((k == 0) ? 1'b0 : 1'(($urandom_range(0, 1))));
      w = 12'($urandom_range(0, 4095));
      bus.DIN_VLD = v;
      bus.DIN     = w;
      exp_q.push_back(pk(1'b0, 1'b0, 1'b1, v ? w : IP));
      tick();
      e = exp_q.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL data_rand %0d: got %h required %h", k, obs, e);
      end
    end
    bus.DIN_VLD = 1'b0;
  endtask

  // finishes the run from tcnt == first_k-1 through marker and the idle first Data word
  task automatic finish_training(input string tag, input int first_k);
    logic [14:0] e;
    for (int k = first_k; k <= 63; k++) begin
      n_run++;
      if (bus.DIN_RDY !== 1'b0) begin
        n_fail++;
        $display("FAIL %s rdy_train %0d: got %b required 0", tag, k, bus.DIN_RDY);
      end
      exp_q.push_back(pk(1'b0, 1'b1, 1'b0, TP));
      tick();
      e = exp_q.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s train %0d: got %h required %h", tag, k, obs, e);
      end
    end
    exp_q.push_back(pk(1'b0, 1'b0, 1'b0, MP));
    exp_q.push_back(pk(1'b0, 1'b0, 1'b1, IP));
    for (int k = 0; k < 2; k++) begin
      tick();
      e = exp_q.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s end %0d: got %h required %h", tag, k, obs, e);
      end
    end
  endtask

  task automatic test_retrain_data();
    logic [14:0] e;
    bus.DIN_VLD = 1'b1;
    bus.DIN     = 12'hABC;
    bus.RETRAIN = 1'b1;
    #1;
    n_run++;
    if (bus.DIN_RDY !== 1'b0) begin
      n_fail++;
      $display("FAIL retrain_rdy: got %b required 0", bus.DIN_RDY);
    end
    exp_q.push_back(pk(1'b0, 1'b1, 1'b0, TP));
    tick();
    e = exp_q.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL retrain_enter: got %h required %h", obs, e);
    end
    bus.RETRAIN = 1'b0;
    bus.DIN     = 12'hDEF;
    finish_training("rtd", 1);
    n_run++;
    if (bus.DIN_RDY !== 1'b1) begin
      n_fail++;
      $display("FAIL retrain_rdy_back: got %b required 1", bus.DIN_RDY);
    end
    exp_q.push_back(pk(1'b0, 1'b0, 1'b1, 12'hDEF));
    tick();
    e = exp_q.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL retrain_first_word: got %h required %h", obs, e);
    end
    bus.DIN_VLD = 1'b0;
  endtask

  task automatic test_retrain_train();
    logic [14:0] e;
    bus.RETRAIN = 1'b1;
    exp_q.push_back(pk(1'b0, 1'b1, 1'b0, TP));
    tick();
    e = exp_q.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL rtt_enter: got %h required %h", obs, e);
    end
    bus.RETRAIN = 1'b0;
    for (int k = 1; k <= 63; k++) begin
      exp_q.push_back(pk(1'b0, 1'b1, 1'b0, TP));
      tick();
      e = exp_q.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL rtt_first_run %0d: got %h required %h", k, obs, e);
      end
    end
    // tcnt is now at its last value; RETRAIN must suppress the marker
    bus.RETRAIN = 1'b1;
    exp_q.push_back(pk(1'b0, 1'b1, 1'b0, TP));
    tick();
    e = exp_q.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL rtt_no_marker: got %h required %h", obs, e);
    end
    bus.RETRAIN = 1'b0;
    finish_training("rtt", 1);
  endtask

  task automatic test_seu();
    logic [14:0] e;
    bus.RETRAIN = 1'b1;
    tick();
    bus.RETRAIN = 1'b0;
    repeat (3) tick();
    force u_dut.state_q1 = 3'h7;
    #2;
    release u_dut.state_q1;
    n_run++;
    if (obs !== pk(1'b0, 1'b1, 1'b0, TP) || bus.DIN_RDY !== 1'b0) begin
      n_fail++;
      $display("FAIL seu_state_out: got %h rdy %b required %h rdy 0", obs, bus.DIN_RDY, pk(1'b0, 1'b1, 1'b0, TP));
    end
    tick();
    n_run++;
    if (u_dut.state_q1 !== 3'd3) begin
      n_fail++;
      $display("FAIL seu_state_fix: got %h required 3", u_dut.state_q1);
    end
    force u_dut.tcnt_q2 = 8'hFF;
    #2;
    release u_dut.tcnt_q2;
    tick();
    n_run++;
    if (u_dut.tcnt_q2 !== 8'd5) begin
      n_fail++;
      $display("FAIL seu_tcnt_fix: got %0d required 5", u_dut.tcnt_q2);
    end
    force u_dut.dout_q0 = 12'h000;
    #2;
    release u_dut.dout_q0;
    n_run++;
    if (obs !== pk(1'b0, 1'b1, 1'b0, TP)) begin
      n_fail++;
      $display("FAIL seu_dout_out: got %h required %h", obs, pk(1'b0, 1'b1, 1'b0, TP));
    end
    exp_q.push_back(pk(1'b0, 1'b1, 1'b0, TP));
    tick();
    e = exp_q.pop_front();
    n_run++;
    if (obs !== e || u_dut.dout_q0 !== TP) begin
      n_fail++;
      $display("FAIL seu_dout_fix: got %h copy %h required %h copy %h", obs, u_dut.dout_q0, e, TP);
    end
    finish_training("seu", 7);
  endtask

  task automatic test_rst_mid();
    bus.DIN_VLD = 1'b1;
    bus.DIN     = 12'h777;
    #1;
    rst = 1'b1;
    #1;
    n_run++;
    if (obs !== 15'h0 || bus.DIN_RDY !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got %h rdy %b required 0000 rdy 0", obs, bus.DIN_RDY);
    end
    bus.DIN_VLD = 1'b0;
    tick();
    run_boot("reboot");
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    test_reset();
    test_data();
    test_retrain_data();
    test_retrain_train();
    test_seu();
    test_rst_mid();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d entries required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
